// File: rtl/uart_rx_mv_sampler.sv
// Oversampling majority-vote bit sampler for the UART receiver.
// Captures 1/3/5/7 samples centred on the bit midpoint and emits the voted bit with a noise flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | sampler disabled or just reset
// WAIT  | enabled mid-bit or after a vote; waits for edge_cnt == 0
// ARMED | collecting samples k = 0..N-1 at edge_cnt == start+k
// VOTE  | one-cycle strobe; voted bit and noise flag were registered on entry

module uart_rx_mv_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int MAX_SAMPLES = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  data_samp_en,
  input  logic [1:0]            samp_mode,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_flag
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED, S_VOTE} state_t;

  localparam logic [2:0] MAX_N = 3'(MAX_SAMPLES);

  state_t                  state;
  logic                    rx_s;
  logic [2:0]              n_lat;
  logic [2:0]              k;
  logic [2:0]              ones;
  logic [2:0]              n_req;
  logic [2:0]              n_sel;
  logic [2:0]              ones_nxt;
  logic [PRESCALE_W-1:0]   half;
  logic [PRESCALE_W-1:0]   off_w;
  logic [PRESCALE_W-1:0]   win_start;
  logic [PRESCALE_W-1:0]   target;
  logic                    vote_bit;
  logic                    vote_noise;
  logic                    last_cap;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= RX_IN;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign n_req = {samp_mode, 1'b1};
  assign n_sel = (n_req > MAX_N) ? MAX_N : n_req;

  // Window start follows the live Prescale; small Prescale clamps the window to edge 0.
  assign half      = Prescale >> 1;
  assign off_w     = PRESCALE_W'((n_lat - 3'd1) >> 1);
  assign win_start = (half < off_w) ? '0 : half - off_w;
  assign target    = win_start + PRESCALE_W'(k);

  assign ones_nxt   = ones + {2'b00, rx_s};
  assign vote_bit   = ones_nxt > (n_lat >> 1);
  assign vote_noise = (ones_nxt != 3'd0) && (ones_nxt != n_lat);
  assign last_cap   = (k == n_lat - 3'd1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      n_lat        <= 3'd1;
      k            <= '0;
      ones         <= '0;
      sampled_bit  <= 1'b0;
      noise_flag   <= 1'b0;
      sample_valid <= 1'b0;
    end else if (!data_samp_en) begin
      state        <= S_IDLE;
      k            <= '0;
      ones         <= '0;
      sampled_bit  <= 1'b0;
      noise_flag   <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      // Every edge_cnt == 0 while enabled starts a fresh bit, including abort of a short bit.
      if (edge_cnt == '0) begin
        state <= S_ARMED;
        n_lat <= n_sel;
        k     <= '0;
        ones  <= '0;
      end else begin
        case (state)
          S_IDLE:  state <= S_WAIT;
          S_WAIT:  state <= S_WAIT;
          S_ARMED: begin
            if (edge_cnt == target) begin
              if (last_cap) begin
                sampled_bit  <= vote_bit;
                noise_flag   <= vote_noise;
                sample_valid <= 1'b1;
                state        <= S_VOTE;
              end else begin
                k    <= k + 3'd1;
                ones <= ones_nxt;
              end
            end
          end
          S_VOTE:  state <= S_WAIT;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mv_sampler.sv
// Bench for uart_rx_mv_sampler: directed test-plan bits plus randomized bit periods,
// checked cycle by cycle against a rule-level reference model.

module tb_uart_rx_mv_sampler;

  localparam int PW   = 6;
  localparam int MAXC = 4096;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic [PW-1:0] edge_cnt;
  logic          data_samp_en;
  logic [1:0]    samp_mode;
  logic          sampled_bit;
  logic          sample_valid;
  logic          noise_flag;

  uart_rx_mv_sampler #(.PRESCALE_W(PW), .MAX_SAMPLES(7), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .edge_cnt(edge_cnt),
    .data_samp_en(data_samp_en), .samp_mode(samp_mode), .sampled_bit(sampled_bit),
    .sample_valid(sample_valid), .noise_flag(noise_flag)
  );

  always #5 CLK = ~CLK;

  bit   st_en [MAXC];
  bit   st_rst[MAXC];
  bit   st_rx [MAXC];
  int   st_edge[MAXC];
  int   st_pre [MAXC];
  int   st_mode[MAXC];
  bit   ex_v[MAXC], ex_b[MAXC], ex_n[MAXC];
  logic ob_v[MAXC], ob_b[MAXC], ob_n[MAXC];
  int   n = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic push(input bit en, input bit rst, input int pre, input int e, input int mode);
    st_en[n] = en; st_rst[n] = rst; st_pre[n] = pre; st_edge[n] = e; st_mode[n] = mode;
    st_rx[n] = 1'($urandom_range(0, 1));
    n++;
  endtask

  task automatic period(input int pre, input int mode, input bit en);
    for (int e = 0; e < pre; e++) push(en, 1'b0, pre, e, mode);
  endtask

  // Sets the synchronised value seen at cycle idx (two flops of delay on the line).
  task automatic set_samp(input int idx, input bit v);
    if (idx >= 2) st_rx[idx-2] = v;
  endtask

  function automatic int n_of(input int mode);
    return (2*mode + 1 > 7) ? 7 : 2*mode + 1;
  endfunction

  function automatic int start_of(input int pre, input int nn);
    int s;
    s = pre/2 - (nn - 1)/2;
    return (s < 0) ? 0 : s;
  endfunction

  task automatic drive(input int i);
    RST          = st_rst[i];
    data_samp_en = st_en[i];
    RX_IN        = st_rx[i];
    Prescale     = PW'(st_pre[i]);
    edge_cnt     = PW'(st_edge[i]);
    samp_mode    = 2'(st_mode[i]);
  endtask

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  int b1, b2, b3, b4f, b5a, b5, b5c, r6, b6b;
  int pat2[5] = '{1, 0, 1, 1, 0};
  int pat5[5] = '{1, 1, 1, 0, 0};

  initial begin
    // ---------------- stimulus construction ----------------
    repeat (3) push(1'b0, 1'b1, 16, 0, 1);
    push(1'b0, 1'b0, 16, 15, 1);

    b1 = n; period(16, 1, 1'b1);
    for (int e = 7; e <= 9; e++) set_samp(b1 + e, 1'b1);

    b2 = n; period(16, 2, 1'b1);
    for (int j = 0; j < 5; j++) set_samp(b2 + 6 + j, 1'(pat2[j]));

    b3 = n; period(8, 3, 1'b1);
    for (int e = 1; e <= 7; e++) set_samp(b3 + e, 1'b0);
    period(8, 3, 1'b1);

    for (int e = 0; e < 5; e++) push(1'b0, 1'b0, 16, e, 1);
    for (int e = 5; e < 16; e++) push(1'b1, 1'b0, 16, e, 1);
    b4f = n; period(16, 1, 1'b1);

    b5a = n; period(16, 2, 1'b1);
    for (int j = 0; j < 5; j++) set_samp(b5a + 6 + j, 1'(pat5[j]));
    b5 = n;
    for (int e = 0; e <= 8; e++) push(1'b1, 1'b0, 16, e, 1);
    for (int e = 9; e < 16; e++) push(1'b0, 1'b0, 16, e, 1);
    b5c = n; period(16, 1, 1'b1);
    set_samp(b5c + 7, 1'b0); set_samp(b5c + 8, 1'b1); set_samp(b5c + 9, 1'b0);

    for (int e = 0; e <= 7; e++) push(1'b1, 1'b0, 16, e, 1);
    r6 = n; push(1'b1, 1'b1, 16, 8, 1);
    b6b = n; period(8, 3, 1'b1);
    for (int i = r6 - 4; i < n; i++) st_rx[i] = 1'b1;

    for (int e = 0; e <= 8; e++) push(1'b1, 1'b0, 16, e, 3);
    period(16, 3, 1'b1);
    for (int e = 0; e <= 7; e++) push(1'b1, 1'b0, 16, e, 1);
    repeat (3) push(1'b1, 1'b0, 16, 7, 1);
    for (int e = 8; e < 16; e++) push(1'b1, 1'b0, 16, e, 1);

    for (int p = 0; p < 40; p++) begin
      int pre, kind, cut, len;
      pre  = 2 * $urandom_range(4, 16);
      kind = $urandom_range(0, 5);
      cut  = $urandom_range(1, pre - 1);
      len  = $urandom_range(1, 3);
      for (int e = 0; e < pre; e++) begin
        int md;
        md = $urandom_range(0, 3);
        if (kind == 1 && e == cut) break;
        if (kind == 2 && e == cut) repeat (len) push(1'b1, 1'b0, pre, e, md);
        push(!(kind == 0 && e >= cut && e < cut + len), 1'b0, pre, e, md);
      end
    end

    // ---------------- reference model ----------------
    begin
      bit armed, hb, hn, v, smp;
      int nn, caps, ones;
      armed = 0; hb = 0; hn = 0; nn = 1; caps = 0; ones = 0;
      for (int i = 0; i < n; i++) begin
        smp = (i >= 2 && !st_rst[i-1] && !st_rst[i-2]) ? st_rx[i-2] : 1'b0;
        v = 0;
        if (st_rst[i] || !st_en[i]) begin
          armed = 0; hb = 0; hn = 0;
        end else if (st_edge[i] == 0) begin
          armed = 1; nn = n_of(st_mode[i]); caps = 0; ones = 0;
        end else if (armed && st_edge[i] == start_of(st_pre[i], nn) + caps) begin
          ones += int'(smp);
          caps++;
          if (caps == nn) begin
            v = 1; hb = (ones > nn/2); hn = (ones != 0 && ones != nn); armed = 0;
          end
        end
        ex_v[i] = v; ex_b[i] = hb; ex_n[i] = hn;
      end
    end

    // ---------------- run ----------------
    drive(0);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      ob_v[i] = sample_valid; ob_b[i] = sampled_bit; ob_n[i] = noise_flag;
      chk("valid", i, ob_v[i], ex_v[i]);
      chk("bit",   i, ob_b[i], ex_b[i]);
      chk("noise", i, ob_n[i], ex_n[i]);
      if (i + 1 < n) drive(i + 1);
    end

    // ---------------- directed test-plan points ----------------
    chk("reset_valid", 2, ob_v[2], 1'b0);
    chk("reset_bit",   2, ob_b[2], 1'b0);
    chk("t1_valid",    b1 + 9,  ob_v[b1 + 9],  1'b1);
    chk("t1_bit",      b1 + 9,  ob_b[b1 + 9],  1'b1);
    chk("t1_noise",    b1 + 9,  ob_n[b1 + 9],  1'b0);
    chk("t1_drop",     b1 + 10, ob_v[b1 + 10], 1'b0);
    chk("t2_valid",    b2 + 10, ob_v[b2 + 10], 1'b1);
    chk("t2_bit",      b2 + 10, ob_b[b2 + 10], 1'b1);
    chk("t2_noise",    b2 + 10, ob_n[b2 + 10], 1'b1);
    chk("t3_valid",    b3 + 7,  ob_v[b3 + 7],  1'b1);
    chk("t3_bit",      b3 + 7,  ob_b[b3 + 7],  1'b0);
    chk("t3_noise",    b3 + 7,  ob_n[b3 + 7],  1'b0);
    chk("t3_rearm",    b3 + 15, ob_v[b3 + 15], 1'b1);
    chk("t4_first",    b4f + 9, ob_v[b4f + 9], 1'b1);
    chk("t5_held_bit", b5 + 8,  ob_b[b5 + 8],  1'b1);
    chk("t5_held_nz",  b5 + 8,  ob_n[b5 + 8],  1'b1);
    chk("t5_dis_bit",  b5 + 9,  ob_b[b5 + 9],  1'b0);
    chk("t5_dis_nz",   b5 + 9,  ob_n[b5 + 9],  1'b0);
    chk("t5_dis_v",    b5 + 9,  ob_v[b5 + 9],  1'b0);
    chk("t5_re_valid", b5c + 9, ob_v[b5c + 9], 1'b1);
    chk("t5_re_bit",   b5c + 9, ob_b[b5c + 9], 1'b0);
    chk("t5_re_noise", b5c + 9, ob_n[b5c + 9], 1'b1);
    chk("t6_rst_nz",   r6,      ob_n[r6],      1'b0);
    chk("t6_rst_v",    r6,      ob_v[r6],      1'b0);
    chk("t6_valid",    b6b + 7, ob_v[b6b + 7], 1'b1);
    chk("t6_bit",      b6b + 7, ob_b[b6b + 7], 1'b1);
    chk("t6_flush",    b6b + 7, ob_n[b6b + 7], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
